// File: rtl/io_output_pkg.sv
// io_output_pkg: op encodings and word decode shared by the IO output bank
package io_output_pkg;

    localparam int OP_W   = 2;
    localparam int PORT_W = 4;

    localparam logic [OP_W-1:0] OP_DATA  = 2'd0;
    localparam logic [OP_W-1:0] OP_SET   = 2'd1;
    localparam logic [OP_W-1:0] OP_CLR   = 2'd2;
    localparam logic [OP_W-1:0] OP_PULSE = 2'd3;

    typedef struct packed {
        logic              hit;
        logic [PORT_W-1:0] port;
        logic [OP_W-1:0]   op;
    } dec_t;

    // Each port owns four consecutive words starting at base; words below base miss.
    function automatic dec_t decode_word(input logic [5:0] base, input logic [5:0] word);
        logic [5:0] off;
        off = word - base;
        return '{hit: word >= base, port: off[5:2], op: off[1:0]};
    endfunction

endpackage

// File: rtl/io_output_port.sv
// io_output_port: one output register with write/set/clear/timed-pulse ops and a change flag
module io_output_port
    import io_output_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PULSE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] value,
    output logic             updated
);

    localparam int            CW   = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_CYCLES);

    logic [WIDTH-1:0] val_q, val_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             upd_q, upd_d;

    // Pulse countdown clears the port on its last step; a write in the same cycle overrides it.
    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) val_d = '0;
        end
        if (we) begin
            val_d = op == OP_SET ? (val_q | wdata) : op == OP_CLR ? (val_q & ~wdata) : wdata;
            cnt_d = op == OP_PULSE ? LOAD : '0;
        end
        upd_d = val_d != val_q;
    end

    // Register state; reset drops any pending pulse without raising the change flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
            upd_q <= 1'b0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
            upd_q <= upd_d;
        end
    end

    assign value   = val_q;
    assign updated = upd_q;

endmodule

// File: rtl/io_output_bank.sv
// io_output_bank: memory-mapped bank of output ports; IO_OUTPUT_BANK_READBACK_EN adds registered rdata
module io_output_bank
    import io_output_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int WIDTH        = 32,
    parameter int BASE_WORD    = 32,
    parameter int PULSE_CYCLES = 1000
) (
    input  logic                       io_clk,
    input  logic                       reset,
    input  logic [31:0]                addr,
    input  logic [31:0]                datain,
    input  logic                       write_io_enable,
    output logic [NUM_PORTS*WIDTH-1:0] out_port,
    output logic [NUM_PORTS-1:0]       port_updated
`ifdef IO_OUTPUT_BANK_READBACK_EN
    ,
    output logic [31:0]                rdata
`endif
);

    localparam logic [5:0] BASE6 = 6'(BASE_WORD);

    dec_t dec;
    logic valid;
    logic unused_bits;

    assign dec         = decode_word(BASE6, addr[7:2]);
    assign valid       = dec.hit && (dec.port < PORT_W'(NUM_PORTS));
    assign unused_bits = ^{addr[31:8], addr[1:0], datain};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        io_output_port #(
            .WIDTH       (WIDTH),
            .PULSE_CYCLES(PULSE_CYCLES)
        ) u_port (
            .clk    (io_clk),
            .rst    (reset),
            .we     (write_io_enable && valid && dec.port == PORT_W'(p)),
            .op     (dec.op),
            .wdata  (datain[WIDTH-1:0]),
            .value  (out_port[p*WIDTH +: WIDTH]),
            .updated(port_updated[p])
        );
    end

`ifdef IO_OUTPUT_BANK_READBACK_EN
    logic [31:0] rdata_q, rdata_d;

    // Select the addressed port's current value; unmapped words read as zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (valid && dec.port == PORT_W'(i)) rdata_d = 32'(out_port[i*WIDTH +: WIDTH]);
    end

    // Readback is registered so it lines up with the store timing.
    always_ff @(posedge io_clk) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_io_output_bank.sv
// tb_io_output_bank: scoreboard bench for io_output_bank (NUM_PORTS=3, WIDTH=32, BASE_WORD=32, PULSE_CYCLES=4)
module tb_io_output_bank;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [95:0] out_port;
    logic [2:0]  port_updated;
`ifdef IO_OUTPUT_BANK_READBACK_EN
    logic [31:0] rdata;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [95:0] out;
        logic [2:0]  upd;
    } exp_t;

    exp_t sb[$];

    io_output_bank #(
        .NUM_PORTS   (3),
        .WIDTH       (32),
        .BASE_WORD   (32),
        .PULSE_CYCLES(4)
    ) dut (
        .io_clk         (io_clk),
        .reset          (reset),
        .addr           (addr),
        .datain         (datain),
        .write_io_enable(write_io_enable),
        .out_port       (out_port),
        .port_updated   (port_updated)
`ifdef IO_OUTPUT_BANK_READBACK_EN
        ,
        .rdata          (rdata)
`endif
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] ov(input logic [31:0] p2, input logic [31:0] p1, input logic [31:0] p0);
        return {p2, p1, p0};
    endfunction

    task automatic step(input logic we, input logic [5:0] word, input logic [31:0] d,
                        input logic [95:0] eo, input logic [2:0] eu, input string tag);
        exp_t e;
        write_io_enable = we;
        addr            = {24'h0, word, 2'b00};
        datain          = d;
        sb.push_back('{tag: tag, out: eo, upd: eu});
        @(posedge io_clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_out"}, out_port, e.out);
        check({e.tag, "_upd"}, {93'b0, port_updated}, {93'b0, e.upd});
    endtask

    initial begin
        reset = 1'b1;
        step(1'b0, 6'd0, 32'h0, ov(0, 0, 0), 3'b000, "rst0");
        step(1'b1, 6'd32, 32'hFF, ov(0, 0, 0), 3'b000, "rst1");
`ifdef IO_OUTPUT_BANK_READBACK_EN
        check("rdata_rst", {64'b0, rdata}, 96'h0);
`endif
        reset = 1'b0;

        step(1'b1, 6'd32, 32'hA5, ov(0, 0, 32'hA5), 3'b001, "p0_data");
        step(1'b0, 6'd32, 32'h0, ov(0, 0, 32'hA5), 3'b000, "p0_idle");
        step(1'b1, 6'd36, 32'hF0, ov(0, 32'hF0, 32'hA5), 3'b010, "p1_data");
        step(1'b1, 6'd37, 32'h0F, ov(0, 32'hFF, 32'hA5), 3'b010, "p1_set");
        step(1'b1, 6'd38, 32'h3C, ov(0, 32'hC3, 32'hA5), 3'b010, "p1_clr");
        step(1'b1, 6'd38, 32'h3C, ov(0, 32'hC3, 32'hA5), 3'b000, "p1_clr_same");

        step(1'b1, 6'd43, 32'h1, ov(1, 32'hC3, 32'hA5), 3'b100, "pulse_k");
        for (int i = 1; i <= 3; i++)
            step(1'b0, 6'd0, 32'h0, ov(1, 32'hC3, 32'hA5), 3'b000, $sformatf("pulse_hold%0d", i));
        step(1'b0, 6'd0, 32'h0, ov(0, 32'hC3, 32'hA5), 3'b100, "pulse_expire");
        step(1'b0, 6'd0, 32'h0, ov(0, 32'hC3, 32'hA5), 3'b000, "pulse_after");

        step(1'b1, 6'd43, 32'h1, ov(1, 32'hC3, 32'hA5), 3'b100, "cancel_pulse");
        step(1'b0, 6'd0, 32'h0, ov(1, 32'hC3, 32'hA5), 3'b000, "cancel_wait");
        step(1'b1, 6'd40, 32'h7, ov(7, 32'hC3, 32'hA5), 3'b100, "cancel_data");
        for (int i = 0; i < 6; i++)
            step(1'b0, 6'd0, 32'h0, ov(7, 32'hC3, 32'hA5), 3'b000, $sformatf("cancel_hold%0d", i));

        step(1'b1, 6'd40, 32'h0, ov(0, 32'hC3, 32'hA5), 3'b100, "re_zero");
        step(1'b1, 6'd43, 32'h1, ov(1, 32'hC3, 32'hA5), 3'b100, "re_pulse");
        for (int i = 1; i <= 3; i++)
            step(1'b0, 6'd0, 32'h0, ov(1, 32'hC3, 32'hA5), 3'b000, $sformatf("re_hold%0d", i));
        step(1'b1, 6'd43, 32'h2, ov(2, 32'hC3, 32'hA5), 3'b100, "re_on_expiry");
        for (int i = 1; i <= 3; i++)
            step(1'b0, 6'd0, 32'h0, ov(2, 32'hC3, 32'hA5), 3'b000, $sformatf("re_hold2_%0d", i));
        step(1'b0, 6'd0, 32'h0, ov(0, 32'hC3, 32'hA5), 3'b100, "re_expire");

        step(1'b1, 6'd44, 32'hFFFF, ov(0, 32'hC3, 32'hA5), 3'b000, "unmapped44");
        step(1'b1, 6'd31, 32'hFFFF, ov(0, 32'hC3, 32'hA5), 3'b000, "below_base");
        step(1'b0, 6'd32, 32'h0, ov(0, 32'hC3, 32'hA5), 3'b000, "we_low");

        step(1'b1, 6'd43, 32'h1, ov(1, 32'hC3, 32'hA5), 3'b100, "rp_pulse");
        step(1'b0, 6'd0, 32'h0, ov(1, 32'hC3, 32'hA5), 3'b000, "rp_wait");
        reset = 1'b1;
        step(1'b1, 6'd32, 32'h55, ov(0, 0, 0), 3'b000, "rp_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            step(1'b0, 6'd0, 32'h0, ov(0, 0, 0), 3'b000, $sformatf("rp_quiet%0d", i));

        step(1'b1, 6'd36, 32'h1234, ov(0, 32'h1234, 0), 3'b010, "rb_write");
`ifdef IO_OUTPUT_BANK_READBACK_EN
        step(1'b0, 6'd38, 32'h0, ov(0, 32'h1234, 0), 3'b000, "rb_read38");
        check("rdata_w38", {64'b0, rdata}, {64'b0, 32'h1234});
        step(1'b0, 6'd50, 32'h0, ov(0, 32'h1234, 0), 3'b000, "rb_read50");
        check("rdata_w50", {64'b0, rdata}, 96'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_output_bank.md
# io_output_bank

Parametrised successor to the single-cycle CPU's memory-mapped output block. It decodes CPU stores into a bank of NUM_PORTS output registers, each WIDTH bits wide. Each register supports plain write, atomic bit-set, atomic bit-clear and a self-clearing timed pulse. It sits on the data-memory side of the IO path and drives LEDs, segment displays and strobes.

## Interface
Parameters:
- NUM_PORTS, 3, number of output registers (1..8).
- WIDTH, 32, bits per port (1..32); datain[WIDTH-1:0] is used.
- BASE_WORD, 32, word index (addr[7:2]) of port 0's DATA register; BASE_WORD + 4*NUM_PORTS must be <= 64.
- PULSE_CYCLES, 1000, number of cycles a PULSE write holds its value (>= 1).

Ports:
- io_clk, in, 1, the single clock; every register changes on its rising edge.
- reset, in, 1, synchronous, active-high.
- addr, in, 32, CPU byte address; only addr[7:2] is decoded.
- datain, in, 32, store data.
- write_io_enable, in, 1, store strobe for the IO space.
- out_port, out, NUM_PORTS*WIDTH, concatenated port values; port p is at [p*WIDTH +: WIDTH].
- port_updated, out, NUM_PORTS, one-cycle flag per port: set when that port's value changed at the last edge.
- rdata, out, 32, registered readback; present only with the configuration macro.

## Operation
- Register map: word = BASE_WORD + 4*p + op, with op 0 DATA, 1 SET, 2 CLR, 3 PULSE.
- DATA: port ← datain. Cancels any pending pulse.
- SET: port ← port | datain. Cancels any pending pulse.
- CLR: port ← port & ~datain. Cancels any pending pulse.
- PULSE: port ← datain and counter ← PULSE_CYCLES. While the counter is non-zero it decrements each cycle. On the 1→0 step the port ← 0.
- Per-port states: IDLE (counter 0) and PULSING (counter > 0).
  - Transitions: PULSE write → PULSING; expiry → IDLE; DATA/SET/CLR → IDLE; reset → IDLE.
- Writes with write_io_enable low, or with a word outside the map, change nothing.
- Simultaneous events:
  - A write and an expiry in the same cycle: the write wins. PULSE reloads the counter; the other ops leave the port IDLE holding the written value.
  - A PULSE to a port already PULSING restarts the count from PULSE_CYCLES.
- port_updated[p] is 1 for exactly the cycle after an edge where out_port[p] changed value. A write of an identical value does not set it. Expiry to 0 sets it if the value was non-zero.
- Counter width is $clog2(PULSE_CYCLES+1). Counters never wrap.
- Reset values: out_port 0, port_updated 0, all counters 0 (IDLE), rdata 0.
- Reset during a pulse: the port is cleared immediately and no expiry event or port_updated follows.

## Timing
- A write sampled at edge k is visible on out_port right after edge k (one-cycle write latency, matching the existing store timing).
- A PULSE sampled at edge k: the port holds datain through edge k+PULSE_CYCLES-1 and reads 0 after edge k+PULSE_CYCLES.
- port_updated is registered and aligned with the new out_port value.
- rdata (when enabled) is the value of the addressed port's register, registered: address presented at edge k gives data after edge k.
  - Any op word of port p returns port p.
  - Unmapped words return 0.
  - Read is independent of write_io_enable.

## Configuration
- IO_OUTPUT_BANK_READBACK_EN defined: the rdata port and its register exist, so software can read back the port values.
- Not defined: the rdata port and its logic are removed. The map is write-only and all other behaviour is identical.

## Structure
- Package io_output_pkg holds:
  - the op encodings OP_DATA/OP_SET/OP_CLR/OP_PULSE (2-bit localparams);
  - the op-field width;
  - a function mapping (BASE_WORD, word) to port index and op.
- Sub-module io_output_port: one register plus its pulse counter and update flag, parametrised by WIDTH and PULSE_CYCLES, instantiated NUM_PORTS times by generate.
- The top level holds the address decode and the readback mux.

## Test plan
- Reset, then DATA write of 0xA5 to word 32 (port 0) → out_port[0]=0xA5 after one edge; port_updated=3'b001 for one cycle.
- Port 1 = 0xF0; SET 0x0F → 0xFF; CLR 0x3C → 0xC3; repeating the same CLR leaves 0xC3 with no port_updated pulse.
- PULSE_CYCLES=4: PULSE 0x1 to port 2 at edge k → port reads 1 for 4 cycles, reads 0 after edge k+4, and port_updated fires at both transitions.
- PULSE to port 2, then DATA 0x7 to port 2 two cycles later → port holds 0x7 indefinitely with no expiry. Separately, a PULSE re-issued exactly on the expiry edge → port stays non-zero and the count restarts.
- reset asserted mid-pulse and during a store → all ports read 0 and no update flags follow. Writes to word 44 (unmapped with NUM_PORTS=3) and writes with write_io_enable=0 → no change.
- With IO_OUTPUT_BANK_READBACK_EN: after writing 0x1234 to port 1, a read at word 38 → rdata=0x1234 one edge later; a read at word 50 → rdata=0.
